// File: rtl/aes_byte_stream_if.sv
// Purpose: bundles the byte-in stream, AES core and byte-out stream signals of aes_byte_stream.
// Latency: none, wires only.
// Backpressure: carries s_ready (input side) and m_ready (output side) handshakes.
//
// Port summary:
//   s_data/s_valid/s_decr/s_ready       byte input stream plus per-block mode
//   core_in/core_decr/core_start        assembled block and launch pulse to the AES core
//   core_out/core_ready                 AES core result (level-valid)
//   m_data/m_valid/m_last/m_ready       byte output stream, m_last marks the 16th byte
//   busy                                block is not in its input-loading phase
// Modports: slave = the byte-stream block, master = its environment (source, core, sink).
interface aes_byte_stream_if;
  logic [7:0]   s_data;
  logic         s_valid;
  logic         s_decr;
  logic         s_ready;
  logic [127:0] core_in;
  logic         core_decr;
  logic         core_start;
  logic [127:0] core_out;
  logic         core_ready;
  logic [7:0]   m_data;
  logic         m_valid;
  logic         m_last;
  logic         m_ready;
  logic         busy;

  modport slave (
    input  s_data, s_valid, s_decr, core_out, core_ready, m_ready,
    output s_ready, core_in, core_decr, core_start, m_data, m_valid, m_last, busy
  );

  modport master (
    output s_data, s_valid, s_decr, core_out, core_ready, m_ready,
    input  s_ready, core_in, core_decr, core_start, m_data, m_valid, m_last, busy
  );
endinterface

// File: rtl/aes_byte_stream.sv
// Purpose: packs 16 input bytes into a 128-bit AES block, launches the core, and streams the result back out bytewise.
// Latency: core_start one cycle after the 16th input accept; first m_valid one cycle after core_ready is captured.
// Backpressure: s_ready only in LOAD (no input/output overlap); m_data/m_last hold while m_valid & !m_ready.
//
// Port summary:
//   clk        single rising-edge clock
//   reset      synchronous, active-low
//   bus        aes_byte_stream_if.slave (byte input, AES core handshake, byte output, busy)
// Parameter MSB_FIRST: 1 = first byte maps to bits [127:120], 0 = first byte maps to bits [7:0].
module aes_byte_stream #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  aes_byte_stream_if.slave bus
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    SEND  = 2'd3
  } state_e;

  state_e       state_q,   state_d;
  logic [3:0]   cnt_q,     cnt_d;
  logic [127:0] in_q,      in_d;
  logic         decr_q,    decr_d;
  logic         start_q,   start_d;
  logic [127:0] out_q,     out_d;
  logic         m_valid_q, m_valid_d;
  logic         m_last_q,  m_last_d;
  logic         s_ready_q, s_ready_d;
  logic         busy_q,    busy_d;

  logic         s_acc;
  logic         m_acc;
  logic [3:0]   slot;
  logic [127:0] out_shift;

  // Handshakes only count in their own phase, so a stray s_valid while busy is simply dropped.
  assign s_acc = (state_q == LOAD) && s_ready_q && bus.s_valid;
  assign m_acc = (state_q == SEND) && m_valid_q && bus.m_ready;

  // Byte slot counted from the top of the block when MSB_FIRST, from the bottom otherwise.
  assign slot = MSB_FIRST ? (4'd15 - cnt_q) : cnt_q;

  // The outgoing byte always sits at the end of out_q that is emitted first; advancing shifts the next one in.
  assign out_shift = MSB_FIRST ? {out_q[119:0], 8'h00} : {8'h00, out_q[127:8]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_d      = in_q;
    decr_d    = decr_q;
    out_d     = out_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;

    unique case (state_q)
      LOAD: begin
        if (s_acc) begin
          in_d[{slot, 3'b000} +: 8] = bus.s_data;
          // Mode travels with the first byte of the block only.
          if (cnt_q == 4'd0) begin
            decr_d = bus.s_decr;
          end
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_d = START;
          end
        end
      end

      START: begin
        // core_ready is deliberately not looked at here: a result still high from
        // a previous operation must not be mistaken for this block's result.
        state_d = WAIT;
      end

      WAIT: begin
        if (bus.core_ready) begin
          out_d     = bus.core_out;
          m_valid_d = 1'b1;
          m_last_d  = 1'b0;
          state_d   = SEND;
        end
      end

      SEND: begin
        if (m_acc) begin
          out_d = out_shift;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            state_d   = LOAD;
          end else begin
            // m_last is registered, so it is raised on the handshake that moves onto byte 15.
            m_last_d = (cnt_q == 4'd14);
          end
        end
      end

      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // Control outputs follow the next state so they are registered and aligned with state_q.
  always_comb begin
    start_d   = (state_d == START);
    s_ready_d = (state_d == LOAD);
    busy_d    = (state_d != LOAD);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= LOAD;
      cnt_q     <= 4'd0;
      in_q      <= 128'd0;
      decr_q    <= 1'b0;
      start_q   <= 1'b0;
      out_q     <= 128'd0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      in_q      <= in_d;
      decr_q    <= decr_d;
      start_q   <= start_d;
      out_q     <= out_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      s_ready_q <= s_ready_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.s_ready    = s_ready_q;
  assign bus.core_in    = in_q;
  assign bus.core_decr  = decr_q;
  assign bus.core_start = start_q;
  assign bus.m_data     = MSB_FIRST ? out_q[127:120] : out_q[7:0];
  assign bus.m_valid    = m_valid_q;
  assign bus.m_last     = m_last_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_aes_byte_stream.sv
// Purpose: self-checking bench for aes_byte_stream, both byte orders driven in lockstep from one stimulus.
// Latency: n/a (bench).
// Backpressure: bench drives m_ready with stalls and random gaps.
module tb_aes_byte_stream;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   s_data;
  logic         s_valid;
  logic         s_decr;
  logic [127:0] core_out;
  logic         core_ready;
  logic         m_ready;

  aes_byte_stream_if b0 ();
  aes_byte_stream_if b1 ();

  assign b0.s_data     = s_data;
  assign b0.s_valid    = s_valid;
  assign b0.s_decr     = s_decr;
  assign b0.core_out   = core_out;
  assign b0.core_ready = core_ready;
  assign b0.m_ready    = m_ready;
  assign b1.s_data     = s_data;
  assign b1.s_valid    = s_valid;
  assign b1.s_decr     = s_decr;
  assign b1.core_out   = core_out;
  assign b1.core_ready = core_ready;
  assign b1.m_ready    = m_ready;

  aes_byte_stream #(.MSB_FIRST(1'b1)) u_msb (.clk(clk), .reset(reset), .bus(b0));
  aes_byte_stream #(.MSB_FIRST(1'b0)) u_lsb (.clk(clk), .reset(reset), .bus(b1));

  always #5 clk = ~clk;

  // Index 0 = MSB_FIRST instance, index 1 = LSB-first instance.
  logic         o_s_ready    [2];
  logic [127:0] o_core_in    [2];
  logic         o_core_decr  [2];
  logic         o_core_start [2];
  logic [7:0]   o_m_data     [2];
  logic         o_m_valid    [2];
  logic         o_m_last     [2];
  logic         o_busy       [2];

  assign o_s_ready[0] = b0.s_ready;       assign o_s_ready[1] = b1.s_ready;
  assign o_core_in[0] = b0.core_in;       assign o_core_in[1] = b1.core_in;
  assign o_core_decr[0] = b0.core_decr;   assign o_core_decr[1] = b1.core_decr;
  assign o_core_start[0] = b0.core_start; assign o_core_start[1] = b1.core_start;
  assign o_m_data[0] = b0.m_data;         assign o_m_data[1] = b1.m_data;
  assign o_m_valid[0] = b0.m_valid;       assign o_m_valid[1] = b1.m_valid;
  assign o_m_last[0] = b0.m_last;         assign o_m_last[1] = b1.m_last;
  assign o_busy[0] = b0.busy;             assign o_busy[1] = b1.busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Observations collected by serve() for the test tasks to judge.
  logic [7:0]   got_b [2][16];
  bit           got_l [2][16];
  int           got_n [2];
  int           first_v [2];
  int           hold_bad [2];
  int           starts [2];
  int           in_chg [2];
  int           srdy_bad [2];

  // Reference model: block packing and byte extraction straight from the byte-order rule.
  function automatic logic [127:0] pack_block(input logic [7:0] b [16], input bit msb);
    logic [127:0] v = '0;
    for (int i = 0; i < 16; i++) begin
      if (msb) v = (v << 8) | 128'(b[i]);
      else     v = v | (128'(b[i]) << (8 * i));
    end
    return v;
  endfunction

  function automatic logic [7:0] nth_byte(input logic [127:0] v, input int i, input bit msb);
    return 8'(v >> (msb ? 8 * (15 - i) : 8 * i));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers 16 bytes; non-first bytes carry the opposite mode so only the first may be latched.
  task automatic feed_block(input logic [7:0] b [16], input bit decr, input bit gapped, output bit ok);
    int i = 0;
    int budget = 200;
    bit gap_phase = 1'b0;
    ok = 1'b1;
    while (i < 16) begin
      if (budget == 0) begin
        ok = 1'b0;
        break;
      end
      budget--;
      if (gapped && gap_phase) begin
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        s_decr  = 1'($urandom);
      end else begin
        s_valid = 1'b1;
        s_data  = b[i];
        s_decr  = (i == 0) ? decr : ~decr;
      end
      if (s_valid && o_s_ready[0]) i++;
      gap_phase = gapped ? ~gap_phase : 1'b0;
      step();
    end
    s_valid = 1'b0;
    s_data  = 8'h00;
    s_decr  = 1'b0;
  endtask

  // Starts in the START cycle (cycle 0). Core model: core_ready high from rdy_at on; core_out shows
  // decoys before and after the cycle the block must capture, so an early or repeated capture is visible.
  task automatic serve(input logic [127:0] res, input int rdy_at, input int stall_idx, input int stall_len,
                       input bit rnd_ready, input int stop_after, output bit ok);
    int cyc = 0;
    int cap;
    int stall_left;
    bit stalled [2];
    logic [7:0] pd [2];
    logic pl [2];
    logic [127:0] in0 [2];
    logic [127:0] va, vb;
    cap = (rdy_at < 1) ? 1 : rdy_at;
    stall_left = stall_len;
    va = {$urandom, $urandom, $urandom, $urandom};
    vb = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < 2; k++) begin
      got_n[k] = 0; first_v[k] = -1; hold_bad[k] = 0; starts[k] = 0;
      in_chg[k] = 0; srdy_bad[k] = 0; stalled[k] = 1'b0; pd[k] = 8'h00; pl[k] = 1'b0;
      in0[k] = o_core_in[k];
    end
    ok = 1'b0;
    while (cyc < 400) begin
      if (stop_after >= 0 && got_n[0] == stop_after) begin ok = 1'b1; break; end
      if (got_n[0] == 16 && got_n[1] == 16) begin ok = 1'b1; break; end
      core_ready = (cyc >= rdy_at);
      core_out   = (cyc < cap) ? va : ((cyc == cap) ? res : vb);
      s_valid    = 1'($urandom_range(0, 1));
      s_data     = 8'($urandom);
      s_decr     = 1'($urandom);
      if (stall_left > 0 && got_n[0] == stall_idx && o_m_valid[0]) begin
        m_ready = 1'b0;
        stall_left--;
      end else begin
        m_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      for (int k = 0; k < 2; k++) begin
        if (o_core_start[k]) starts[k]++;
        if (o_core_in[k] !== in0[k]) in_chg[k]++;
        if (o_s_ready[k]) srdy_bad[k]++;
        if (o_m_valid[k]) begin
          if (first_v[k] < 0) first_v[k] = cyc;
          if (stalled[k] && (o_m_data[k] !== pd[k] || o_m_last[k] !== pl[k])) hold_bad[k]++;
          if (m_ready && got_n[k] < 16) begin
            got_b[k][got_n[k]] = o_m_data[k];
            got_l[k][got_n[k]] = o_m_last[k];
            got_n[k]++;
          end
          stalled[k] = !m_ready;
          pd[k] = o_m_data[k];
          pl[k] = o_m_last[k];
        end else begin
          stalled[k] = 1'b0;
        end
      end
      step();
      cyc++;
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    core_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; s_valid = 1'b1; s_data = 8'h5a; s_decr = 1'b1;
    core_out = '0; core_ready = 1'b1; m_ready = 1'b0;
    step();
    step();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({o_s_ready[k], o_m_valid[k], o_m_last[k], o_core_start[k], o_busy[k], o_core_decr[k]} !== 6'b0) begin
        n_bad++;
        $display("FAIL reset_ctrl inst%0d: got %b want 000000", k,
                 {o_s_ready[k], o_m_valid[k], o_m_last[k], o_core_start[k], o_busy[k], o_core_decr[k]});
      end
      n_cmp++;
      if (o_core_in[k] !== 128'd0 || o_m_data[k] !== 8'd0) begin
        n_bad++;
        $display("FAIL reset_data inst%0d: core_in=%h m_data=%h want zeros", k, o_core_in[k], o_m_data[k]);
      end
    end
    s_valid = 1'b0; core_ready = 1'b0;
    reset = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (o_s_ready[k] !== 1'b1 || o_busy[k] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_release inst%0d: s_ready=%b busy=%b want 1 0", k, o_s_ready[k], o_busy[k]);
      end
    end
  endtask

  task automatic test_normal();
    logic [7:0] b [16];
    logic [127:0] res;
    bit ok;
    for (int i = 0; i < 16; i++) b[i] = 8'(i * 17);
    res = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    feed_block(b, 1'b0, 1'b0, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL normal_feed: got timeout want 16 accepts"); end
    n_cmp++;
    if (o_core_in[0] !== 128'h00112233445566778899aabbccddeeff) begin
      n_bad++; $display("FAIL normal_vector: core_in=%h want 00112233445566778899aabbccddeeff", o_core_in[0]);
    end
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (o_core_start[k] !== 1'b1 || o_s_ready[k] !== 1'b0 || o_busy[k] !== 1'b1) begin
        n_bad++; $display("FAIL normal_start inst%0d: start=%b s_ready=%b busy=%b want 1 0 1", k,
                          o_core_start[k], o_s_ready[k], o_busy[k]);
      end
      n_cmp++;
      if (o_core_in[k] !== pack_block(b, k == 0) || o_core_decr[k] !== 1'b0) begin
        n_bad++; $display("FAIL normal_core_in inst%0d: got %h/%b want %h/0", k, o_core_in[k], o_core_decr[k],
                          pack_block(b, k == 0));
      end
    end
    serve(res, 20, -1, 0, 1'b0, -1, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL normal_drain: got timeout want 16 bytes"); end
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (starts[k] != 1 || in_chg[k] != 0 || srdy_bad[k] != 0 || first_v[k] != 21) begin
        n_bad++; $display("FAIL normal_timing inst%0d: starts=%0d in_chg=%0d s_ready_hi=%0d first_v=%0d want 1 0 0 21",
                          k, starts[k], in_chg[k], srdy_bad[k], first_v[k]);
      end
      for (int i = 0; i < 16; i++) begin
        n_cmp++;
        if (got_b[k][i] !== nth_byte(res, i, k == 0) || got_l[k][i] !== (i == 15)) begin
          n_bad++; $display("FAIL normal_byte inst%0d[%0d]: got %h last=%b want %h last=%b", k, i,
                            got_b[k][i], got_l[k][i], nth_byte(res, i, k == 0), (i == 15));
        end
      end
      n_cmp++;
      if (o_s_ready[k] !== 1'b1 || o_busy[k] !== 1'b0 || o_m_valid[k] !== 1'b0) begin
        n_bad++; $display("FAIL normal_to_load inst%0d: s_ready=%b busy=%b m_valid=%b want 1 0 0", k,
                          o_s_ready[k], o_busy[k], o_m_valid[k]);
      end
    end
  endtask

  task automatic test_gapped();
    logic [7:0] b [16];
    logic [127:0] res;
    int rdy_at;
    bit ok;
    for (int i = 0; i < 16; i++) b[i] = 8'(i * 17);
    res = {$urandom, $urandom, $urandom, $urandom};
    rdy_at = $urandom_range(2, 9);
    feed_block(b, 1'b1, 1'b1, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL gapped_feed: got timeout want 16 accepts"); end
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (o_core_in[k] !== pack_block(b, k == 0) || o_core_decr[k] !== 1'b1 || o_core_start[k] !== 1'b1) begin
        n_bad++; $display("FAIL gapped_core_in inst%0d: got %h decr=%b start=%b want %h 1 1", k, o_core_in[k],
                          o_core_decr[k], o_core_start[k], pack_block(b, k == 0));
      end
    end
    serve(res, rdy_at, -1, 0, 1'b0, -1, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL gapped_drain: got timeout want 16 bytes"); end
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (first_v[k] != rdy_at + 1 || o_core_decr[k] !== 1'b1) begin
        n_bad++; $display("FAIL gapped_latency inst%0d: first_v=%0d decr=%b want %0d 1", k, first_v[k],
                          o_core_decr[k], rdy_at + 1);
      end
      for (int i = 0; i < 16; i++) begin
        n_cmp++;
        if (got_b[k][i] !== nth_byte(res, i, k == 0) || got_l[k][i] !== (i == 15)) begin
          n_bad++; $display("FAIL gapped_byte inst%0d[%0d]: got %h last=%b want %h", k, i, got_b[k][i],
                            got_l[k][i], nth_byte(res, i, k == 0));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] b [16];
    logic [127:0] res;
    bit ok;
    for (int i = 0; i < 16; i++) b[i] = 8'($urandom);
    res = {$urandom, $urandom, $urandom, $urandom};
    feed_block(b, 1'b0, 1'b0, ok);
    serve(res, 4, 5, 3, 1'b0, -1, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL bp_drain: got timeout want 16 bytes"); end
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (hold_bad[k] != 0 || got_n[k] != 16) begin
        n_bad++; $display("FAIL bp_hold inst%0d: hold_violations=%0d bytes=%0d want 0 16", k, hold_bad[k], got_n[k]);
      end
      for (int i = 0; i < 16; i++) begin
        n_cmp++;
        if (got_b[k][i] !== nth_byte(res, i, k == 0) || got_l[k][i] !== (i == 15)) begin
          n_bad++; $display("FAIL bp_byte inst%0d[%0d]: got %h last=%b want %h", k, i, got_b[k][i],
                            got_l[k][i], nth_byte(res, i, k == 0));
        end
      end
    end
  endtask

  task automatic test_core_early();
    logic [7:0] b [16];
    logic [127:0] res;
    bit ok;
    for (int i = 0; i < 16; i++) b[i] = 8'($urandom);
    res = {$urandom, $urandom, $urandom, $urandom};
    feed_block(b, 1'b1, 1'b0, ok);
    serve(res, 0, -1, 0, 1'b0, -1, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL early_drain: got timeout want 16 bytes"); end
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (first_v[k] != 2 || starts[k] != 1) begin
        n_bad++; $display("FAIL early_latency inst%0d: first_v=%0d starts=%0d want 2 1", k, first_v[k], starts[k]);
      end
      for (int i = 0; i < 16; i++) begin
        n_cmp++;
        if (got_b[k][i] !== nth_byte(res, i, k == 0)) begin
          n_bad++; $display("FAIL early_byte inst%0d[%0d]: got %h want %h", k, i, got_b[k][i], nth_byte(res, i, k == 0));
        end
      end
    end
  endtask

  task automatic test_reset_mid_send();
    logic [7:0] b [16];
    logic [127:0] res;
    bit ok;
    for (int i = 0; i < 16; i++) b[i] = 8'($urandom);
    res = {$urandom, $urandom, $urandom, $urandom};
    feed_block(b, 1'b0, 1'b0, ok);
    serve(res, 3, -1, 0, 1'b0, 7, ok);
    n_cmp++;
    if (!ok || got_b[0][6] !== nth_byte(res, 6, 1'b1)) begin
      n_bad++; $display("FAIL rst_pre_bytes: ok=%b byte6=%h want 1 %h", ok, got_b[0][6], nth_byte(res, 6, 1'b1));
    end
    reset = 1'b0;
    core_ready = 1'b1;
    core_out = {$urandom, $urandom, $urandom, $urandom};
    m_ready = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (o_m_valid[k] !== 1'b0 || o_m_last[k] !== 1'b0 || o_s_ready[k] !== 1'b0 || o_busy[k] !== 1'b0) begin
        n_bad++; $display("FAIL rst_mid_send inst%0d: m_valid=%b m_last=%b s_ready=%b busy=%b want 0 0 0 0", k,
                          o_m_valid[k], o_m_last[k], o_s_ready[k], o_busy[k]);
      end
    end
    reset = 1'b1;
    // A lingering core_ready must not revive the discarded block.
    for (int c = 0; c < 4; c++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (o_m_valid[k] !== 1'b0 || o_s_ready[k] !== 1'b1 || o_busy[k] !== 1'b0) begin
          n_bad++; $display("FAIL rst_after inst%0d cyc%0d: m_valid=%b s_ready=%b busy=%b want 0 1 0", k, c,
                            o_m_valid[k], o_s_ready[k], o_busy[k]);
        end
      end
    end
    core_ready = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) b[i] = 8'($urandom);
    res = {$urandom, $urandom, $urandom, $urandom};
    feed_block(b, 1'b1, 1'b0, ok);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (o_core_in[k] !== pack_block(b, k == 0) || o_core_decr[k] !== 1'b1) begin
        n_bad++; $display("FAIL rst_fresh_in inst%0d: got %h/%b want %h/1", k, o_core_in[k], o_core_decr[k],
                          pack_block(b, k == 0));
      end
    end
    serve(res, 5, -1, 0, 1'b1, -1, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL rst_fresh_drain: got timeout want 16 bytes"); end
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) begin
        n_cmp++;
        if (got_b[k][i] !== nth_byte(res, i, k == 0) || got_l[k][i] !== (i == 15)) begin
          n_bad++; $display("FAIL rst_fresh_byte inst%0d[%0d]: got %h want %h", k, i, got_b[k][i], nth_byte(res, i, k == 0));
        end
      end
    end
  endtask

  task automatic test_lsb_vector();
    logic [7:0] b [16];
    logic [127:0] res;
    bit ok;
    for (int i = 0; i < 16; i++) b[i] = 8'(i);
    res = {$urandom, $urandom, $urandom, $urandom};
    feed_block(b, 1'b0, 1'b0, ok);
    n_cmp++;
    if (o_core_in[1] !== 128'h0f0e0d0c0b0a09080706050403020100) begin
      n_bad++; $display("FAIL lsb_vector: core_in=%h want 0f0e0d0c0b0a09080706050403020100", o_core_in[1]);
    end
    n_cmp++;
    if (o_core_in[0] !== 128'h000102030405060708090a0b0c0d0e0f) begin
      n_bad++; $display("FAIL msb_vector: core_in=%h want 000102030405060708090a0b0c0d0e0f", o_core_in[0]);
    end
    serve(res, 6, -1, 0, 1'b0, -1, ok);
    n_cmp++;
    if (!ok || got_b[1][0] !== res[7:0] || got_b[1][15] !== res[127:120]) begin
      n_bad++; $display("FAIL lsb_order: ok=%b first=%h last=%h want 1 %h %h", ok, got_b[1][0], got_b[1][15],
                        res[7:0], res[127:120]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b [16];
    logic [127:0] res;
    bit decr;
    int rdy_at;
    bit ok;
    for (int blk = 0; blk < 3; blk++) begin
      for (int i = 0; i < 16; i++) b[i] = 8'($urandom);
      res = {$urandom, $urandom, $urandom, $urandom};
      decr = 1'($urandom);
      rdy_at = $urandom_range(0, 12);
      feed_block(b, decr, 1'($urandom), ok);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (!ok || o_core_in[k] !== pack_block(b, k == 0) || o_core_decr[k] !== decr) begin
          n_bad++; $display("FAIL b2b_core_in blk%0d inst%0d: got %h/%b want %h/%b", blk, k, o_core_in[k],
                            o_core_decr[k], pack_block(b, k == 0), decr);
        end
      end
      serve(res, rdy_at, -1, 0, 1'b1, -1, ok);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (!ok || first_v[k] != ((rdy_at < 1) ? 2 : rdy_at + 1) || hold_bad[k] != 0 || srdy_bad[k] != 0) begin
          n_bad++; $display("FAIL b2b_flow blk%0d inst%0d: ok=%b first_v=%0d hold=%0d s_ready_hi=%0d rdy_at=%0d",
                            blk, k, ok, first_v[k], hold_bad[k], srdy_bad[k], rdy_at);
        end
        for (int i = 0; i < 16; i++) begin
          n_cmp++;
          if (got_b[k][i] !== nth_byte(res, i, k == 0) || got_l[k][i] !== (i == 15)) begin
            n_bad++; $display("FAIL b2b_byte blk%0d inst%0d[%0d]: got %h want %h", blk, k, i, got_b[k][i],
                              nth_byte(res, i, k == 0));
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_gapped();
    test_backpressure();
    test_core_early();
    test_reset_mid_send();
    test_lsb_vector();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion within 500000 time units want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
